// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file.
//   DATA_W_DEF/DEPTH_DEF/NUM_RD_DEF/NUM_WR_DEF : default sizing
//   MAX_WR/MAX_AW : widest write-port set / address that wr_select() handles
//   reg_data_t    : register data word at default width
//   wr_select()   : highest-index enabled write port hitting an address
package regfile_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned DEPTH_DEF  = 32;
  localparam int unsigned NUM_RD_DEF = 2;
  localparam int unsigned NUM_WR_DEF = 1;

  localparam int unsigned MAX_WR = 4;
  localparam int unsigned MAX_AW = 16;

  typedef logic [DATA_W_DEF-1:0] reg_data_t;

  typedef struct packed {
    logic       hit;
    logic [1:0] port;
  } wr_sel_t;

  typedef logic [MAX_WR-1:0][MAX_AW-1:0] wr_addr_vec_t;

  // Later ports overwrite earlier ones, so the highest matching index wins.
  function automatic wr_sel_t wr_select(input logic [MAX_WR-1:0] en,
                                        input wr_addr_vec_t       addr,
                                        input logic [MAX_AW-1:0]  a);
    wr_sel_t r;
    r = '0;
    for (int p = 0; p < int'(MAX_WR); p++) begin
      if (en[p] && (addr[p] == a)) begin
        r.hit  = 1'b1;
        r.port = 2'(p);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy scoreboard: reservations set, committed writes clear.
//   clk, reset : clock, synchronous active-high reset
//   clr_vec    : one bit per register, committed write this cycle
//   rsv_en     : reservation request for rsv_addr
//   busy       : registered busy vector
//   rsv_stall  : reservation refused because the register is busy
// With RF_BYPASS_EN defined, a register released this cycle counts as free
// for the stall decision.
module rf_scoreboard
  import regfile_pkg::*;
#(
  parameter  int unsigned DEPTH    = DEPTH_DEF,
  parameter  int unsigned ZERO_REG = 1,
  localparam int unsigned AW       = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DEPTH-1:0] clr_vec,
  input  logic             rsv_en,
  input  logic [AW-1:0]    rsv_addr,
  output logic [DEPTH-1:0] busy,
  output logic             rsv_stall
);

  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;
  logic             busy_at_rsv;
  logic             rsv_take;

  // Stall decision and next busy vector; reserve beats a same-cycle clear.
  always_comb begin
    busy_at_rsv = busy_q[rsv_addr];
`ifdef RF_BYPASS_EN
    if (clr_vec[rsv_addr]) busy_at_rsv = 1'b0;
`endif
    rsv_stall = rsv_en && busy_at_rsv;
    rsv_take  = rsv_en && !busy_at_rsv && !((ZERO_REG != 0) && (rsv_addr == '0));
    busy_d    = busy_q & ~clr_vec;
    if (rsv_take) busy_d[rsv_addr] = 1'b1;
    if (ZERO_REG != 0) busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) busy_q <= '0;
    else       busy_q <= busy_d;
  end

  assign busy = busy_q;

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-port register file with busy scoreboard.
//   clk, reset          : clock, synchronous active-high reset
//   rd_addr/rd_data/rd_busy : NUM_RD combinational read ports
//   wr_en/wr_addr/wr_data   : NUM_WR write ports, committed on the edge
//   rsv_en/rsv_addr/rsv_stall : issue-stage reservation interface
// Optional macro RF_BYPASS_EN: same-cycle writes are forwarded to reads and
// release busy for the reads and the stall decision.
module regfile_mp_sb
  import regfile_pkg::*;
#(
  parameter  int unsigned DATA_W   = DATA_W_DEF,
  parameter  int unsigned DEPTH    = DEPTH_DEF,
  parameter  int unsigned NUM_RD   = NUM_RD_DEF,
  parameter  int unsigned NUM_WR   = NUM_WR_DEF,
  parameter  int unsigned ZERO_REG = 1,
  localparam int unsigned AW       = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_RD*AW-1:0]     rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*AW-1:0]     wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  input  logic                     rsv_en,
  input  logic [AW-1:0]            rsv_addr,
  output logic                     rsv_stall
);

  logic [MAX_WR-1:0] wen_pad;
  wr_addr_vec_t      waddr_pad;
  logic [DATA_W-1:0] wdata_pad [MAX_WR];
  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0]  wr_hit;
  logic [DEPTH-1:0]  busy;

  // Widen the write ports to the fixed shape wr_select() expects.
  for (genvar p = 0; p < int'(MAX_WR); p++) begin : g_pad
    if (p < int'(NUM_WR)) begin : g_used
      assign wen_pad[p]   = wr_en[p];
      assign waddr_pad[p] = MAX_AW'(wr_addr[p*AW +: AW]);
      assign wdata_pad[p] = wr_data[p*DATA_W +: DATA_W];
    end else begin : g_unused
      assign wen_pad[p]   = 1'b0;
      assign waddr_pad[p] = '0;
      assign wdata_pad[p] = '0;
    end
  end

  // Per-register write commit; register 0 drops writes when hardwired.
  for (genvar a = 0; a < int'(DEPTH); a++) begin : g_wr
    wr_sel_t wsel;
    assign wsel      = wr_select(wen_pad, waddr_pad, MAX_AW'(a));
    assign wr_hit[a] = wsel.hit && !((ZERO_REG != 0) && (a == 0));
    assign regs_d[a] = wr_hit[a] ? wdata_pad[wsel.port] : regs_q[a];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  rf_scoreboard #(
    .DEPTH    (DEPTH),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk       (clk),
    .reset     (reset),
    .clr_vec   (wr_hit),
    .rsv_en    (rsv_en),
    .rsv_addr  (rsv_addr),
    .busy      (busy),
    .rsv_stall (rsv_stall)
  );

  // Combinational read muxes.
  for (genvar p = 0; p < int'(NUM_RD); p++) begin : g_rd
    logic [AW-1:0]     ra;
    logic [DATA_W-1:0] data;
    logic              bsy;
    assign ra = rd_addr[p*AW +: AW];

    always_comb begin
      data = regs_q[ra];
      bsy  = busy[ra];
`ifdef RF_BYPASS_EN
      begin
        wr_sel_t rsel;
        rsel = wr_select(wen_pad, waddr_pad, MAX_AW'(ra));
        // Forwarded write releases busy unless it is re-reserved right now.
        if (rsel.hit) begin
          data = wdata_pad[rsel.port];
          bsy  = rsv_en && !rsv_stall && (rsv_addr == ra);
        end
      end
`endif
      if ((ZERO_REG != 0) && (ra == '0)) begin
        data = '0;
        bsy  = 1'b0;
      end
    end

    assign rd_data[p*DATA_W +: DATA_W] = data;
    assign rd_busy[p]                  = bsy;
  end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Directed, table-driven bench for regfile_mp_sb (2 read, 2 write ports).
module tb_regfile_mp_sb;

`ifdef RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic [1:0]  wr_en;
  logic [9:0]  wr_addr;
  logic [63:0] wr_data;
  logic        rsv_en;
  logic [4:0]  rsv_addr;
  logic        rsv_stall;

  regfile_mp_sb #(
    .DATA_W(32), .DEPTH(32), .NUM_RD(2), .NUM_WR(2), .ZERO_REG(1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .rd_busy   (rd_busy),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rsv_en    (rsv_en),
    .rsv_addr  (rsv_addr),
    .rsv_stall (rsv_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic drive(input logic [1:0] we, input logic [4:0] wa0, input logic [4:0] wa1,
                       input logic [31:0] wd0, input logic [31:0] wd1,
                       input logic rsv, input logic [4:0] ra,
                       input logic [4:0] r0, input logic [4:0] r1);
    wr_en    = we;
    wr_addr  = {wa1, wa0};
    wr_data  = {wd1, wd0};
    rsv_en   = rsv;
    rsv_addr = ra;
    rd_addr  = {r1, r0};
  endtask

  typedef struct {
    string       name;
    logic [1:0]  we;
    logic [4:0]  wa0, wa1;
    logic [31:0] wd0, wd1;
    logic        rsv;
    logic [4:0]  ra;
    logic [4:0]  rd0, rd1;
    logic [31:0] e0, e1;
    logic [1:0]  eb;
    logic        es;
  } vec_t;

  vec_t vq[$];

  initial begin
    // Fields: name, we, wa0, wa1, wd0, wd1, rsv, ra, rd0, rd1, exp0, exp1, exp_busy, exp_stall
    vq.push_back('{"dual_wr_r5",   2'b11, 5'd5, 5'd5, 32'h11, 32'h22, 1'b0, 5'd0, 5'd6, 5'd0, 32'h0, 32'h0, 2'b00, 1'b0});
    vq.push_back('{"r5_hi_port",   2'b01, 5'd0, 5'd0, 32'hDEADBEEF, 32'h0, 1'b0, 5'd0, 5'd5, 5'd0, 32'h22, 32'h0, 2'b00, 1'b0});
    vq.push_back('{"rsv_r0",       2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b1, 5'd0, 5'd0, 5'd5, 32'h0, 32'h22, 2'b00, 1'b0});
    vq.push_back('{"rsv_r7",       2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b1, 5'd7, 5'd0, 5'd7, 32'h0, 32'h0, 2'b00, 1'b0});
    vq.push_back('{"rsv_r7_again", 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b1, 5'd7, 5'd7, 5'd0, 32'h0, 32'h0, 2'b01, 1'b1});
    vq.push_back('{"wr_r7",        2'b01, 5'd7, 5'd0, 32'h77, 32'h0, 1'b0, 5'd0, 5'd5, 5'd9, 32'h22, 32'h0, 2'b00, 1'b0});
    vq.push_back('{"rsv_wr_r9",    2'b01, 5'd9, 5'd0, 32'h99, 32'h0, 1'b1, 5'd9, 5'd7, 5'd5, 32'h77, 32'h22, 2'b00, 1'b0});
    vq.push_back('{"r9_busy",      2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b1, 5'd9, 5'd9, 5'd7, 32'h99, 32'h77, 2'b01, 1'b1});
    vq.push_back('{"wr_r10_r11",   2'b11, 5'd10, 5'd11, 32'hA, 32'hB, 1'b0, 5'd0, 5'd9, 5'd0, 32'h99, 32'h0, 2'b01, 1'b0});
    vq.push_back('{"rd_r10_r11",   2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd10, 5'd11, 32'hA, 32'hB, 2'b00, 1'b0});
    vq.push_back('{"rel_rsv_r9",   2'b10, 5'd0, 5'd9, 32'h0, 32'h1234, 1'b1, 5'd9, 5'd10, 5'd11, 32'hA, 32'hB, 2'b00, !BYP});
    vq.push_back('{"r9_after",     2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd0, 32'h1234, 32'h0, {1'b0, BYP}, 1'b0});

    reset = 1'b1;
    drive(2'b00, 0, 0, 0, 0, 1'b0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;

    // Fill with random contents and some reservations.
    reset = 1'b0;
    for (int i = 0; i < 16; i++) begin
      drive(2'b11, 5'(2*i), 5'(2*i+1), $urandom, $urandom, 1'b1, 5'(i+1), 0, 0);
      @(posedge clk);
      #1;
    end

    // Reset edge with a competing write and reservation.
    reset = 1'b1;
    drive(2'b11, 5'd1, 5'd2, 32'h5555, 32'h6666, 1'b1, 5'd3, 0, 0);
    @(posedge clk);
    #1;

    // Scan all registers while reset is still held.
    for (int k = 0; k < 16; k++) begin
      drive(2'b00, 0, 0, 0, 0, 1'b1, 5'(2*k+1), 5'(2*k), 5'(2*k+1));
      @(negedge clk);
      chk($sformatf("rst_data_r%0d", 2*k), rd_data[31:0], 32'h0);
      chk($sformatf("rst_data_r%0d", 2*k+1), rd_data[63:32], 32'h0);
      chk($sformatf("rst_busy_r%0d_r%0d", 2*k, 2*k+1), 32'(rd_busy), 32'h0);
      chk($sformatf("rst_stall_r%0d", 2*k+1), 32'(rsv_stall), 32'h0);
      @(posedge clk);
      #1;
    end
    reset = 1'b0;

    foreach (vq[i]) begin
      drive(vq[i].we, vq[i].wa0, vq[i].wa1, vq[i].wd0, vq[i].wd1,
            vq[i].rsv, vq[i].ra, vq[i].rd0, vq[i].rd1);
      @(negedge clk);
      chk({vq[i].name, "_rd0"}, rd_data[31:0], vq[i].e0);
      chk({vq[i].name, "_rd1"}, rd_data[63:32], vq[i].e1);
      chk({vq[i].name, "_busy"}, 32'(rd_busy), 32'(vq[i].eb));
      chk({vq[i].name, "_stall"}, 32'(rsv_stall), 32'(vq[i].es));
      @(posedge clk);
      #1;
    end

    // Write r3 while reading it: forwarded same cycle only with bypass.
    drive(2'b01, 5'd3, 5'd0, 32'hCAFE, 32'h0, 1'b0, 0, 5'd3, 5'd0);
    @(negedge clk);
    chk("r3_same_cycle", rd_data[31:0], BYP ? 32'hCAFE : 32'h0);
    @(posedge clk);
    #1;
    drive(2'b00, 0, 0, 0, 0, 1'b0, 0, 5'd3, 5'd0);
    @(negedge clk);
    chk("r3_next_cycle", rd_data[31:0], 32'hCAFE);
    @(posedge clk);
    #1;

    // Reserve r12, then release it while reading.
    drive(2'b00, 0, 0, 0, 0, 1'b1, 5'd12, 5'd12, 5'd0);
    @(posedge clk);
    #1;
    drive(2'b10, 5'd0, 5'd12, 32'h0, 32'h5A, 1'b0, 0, 5'd12, 5'd0);
    @(negedge clk);
    chk("r12_rel_busy", 32'(rd_busy[0]), BYP ? 32'h0 : 32'h1);
    chk("r12_rel_data", rd_data[31:0], BYP ? 32'h5A : 32'h0);
    @(posedge clk);
    #1;
    drive(2'b00, 0, 0, 0, 0, 1'b1, 5'd12, 5'd12, 5'd0);
    @(negedge clk);
    chk("r12_after_busy", 32'(rd_busy[0]), 32'h0);
    chk("r12_after_data", rd_data[31:0], 32'h5A);
    chk("r12_after_stall", 32'(rsv_stall), 32'h0);
    @(posedge clk);
    #1;
    drive(2'b00, 0, 0, 0, 0, 1'b0, 0, 5'd12, 5'd0);
    @(negedge clk);
    chk("r12_rebusy", 32'(rd_busy[0]), 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
